// File: rtl/mhp_tx.sv
// mhp_tx: serialises one MHP frame (header, BRAM payload, checksum, zero pad) onto a byte write port.
// Each byte takes a WAIT phase (until i_wready) and a one-cycle SEND phase with o_wvalid high.
module mhp_tx #(
  parameter int ADDR_W    = 10,
  parameter int MAX_LEN   = 1015,
  parameter int MIN_FRAME = 46
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [15:0]       i_dst_addr,
  input  logic [15:0]       i_src_addr,
  input  logic [7:0]        i_d_type,
  input  logic [15:0]       i_len,
  output logic [ADDR_W-1:0] o_paddr,
  output logic              o_pren,
  input  logic [7:0]        i_pdata,
  output logic [7:0]        o_wdata,
  input  logic              i_wready,
  output logic              o_wvalid,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  typedef enum logic [2:0] {IDLE, HDR, PAY, CSUM, PAD, DONE} state_t;
  localparam logic [15:0] L_MAX = 16'(MAX_LEN);
  localparam logic [15:0] L_MIN = 16'(MIN_FRAME);
  state_t      r_state, w_next;
  logic [15:0] r_dst, r_src, r_len, r_idx, r_csum, r_rcnt;
  logic [7:0]  r_type, r_pbuf, w_byte, w_pd;
  logic        r_pfull, r_pv;
  logic        w_acc, w_rej, w_byte_st, w_sent, w_go, w_take, w_rd;
  assign w_acc     = r_state == IDLE && i_start && i_len <= L_MAX;
  assign w_rej     = r_state == IDLE && i_start && i_len > L_MAX;
  assign w_byte_st = r_state inside {HDR, PAY, CSUM, PAD};
  assign w_sent    = w_byte_st && o_wvalid;
  // payload byte comes from the one-entry buffer or straight off the BRAM in its valid cycle
  assign w_pd      = r_pfull ? r_pbuf : i_pdata;
  assign w_go      = w_byte_st && !o_wvalid && i_wready && (r_state != PAY || r_pfull || r_pv);
  assign w_take    = w_go && r_state == PAY;
  // at most one payload byte held or in flight; the next read is issued as the current one is taken
  assign w_rd      = r_state inside {HDR, PAY, CSUM} && r_rcnt < r_len && !o_pren &&
                     (w_take || (!r_pfull && !r_pv));
  always_comb begin
    w_byte = 8'h00;
    case (r_state)
      HDR:     w_byte = r_idx[2:0] == 3'd0 ? r_dst[15:8] :
                        r_idx[2:0] == 3'd1 ? r_dst[7:0]  :
                        r_idx[2:0] == 3'd2 ? r_src[15:8] :
                        r_idx[2:0] == 3'd3 ? r_src[7:0]  :
                        r_idx[2:0] == 3'd4 ? r_len[15:8] :
                        r_idx[2:0] == 3'd5 ? r_len[7:0]  : r_type;
      PAY:     w_byte = w_pd;
      CSUM:    w_byte = r_idx == r_len + 16'd7 ? r_csum[15:8] : r_csum[7:0];
      default: w_byte = 8'h00;
    endcase
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? HDR : IDLE;
      HDR:     w_next = w_sent && r_idx == 16'd6 ? (r_len == 16'd0 ? CSUM : PAY) : HDR;
      PAY:     w_next = w_sent && r_idx == r_len + 16'd6 ? CSUM : PAY;
      CSUM:    w_next = w_sent && r_idx == r_len + 16'd8 ? (r_len >= L_MIN - 16'd9 ? DONE : PAD) : CSUM;
      PAD:     w_next = w_sent && r_idx == L_MIN - 16'd1 ? DONE : PAD;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_next;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_err    <= 1'b0;
      o_done   <= 1'b0;
      o_busy   <= 1'b0;
      o_wvalid <= 1'b0;
      o_wdata  <= '0;
      o_pren   <= 1'b0;
      o_paddr  <= '0;
      r_pv     <= 1'b0;
      r_pfull  <= 1'b0;
      r_pbuf   <= '0;
      r_dst    <= '0;
      r_src    <= '0;
      r_len    <= '0;
      r_type   <= '0;
      r_idx    <= '0;
      r_csum   <= '0;
      r_rcnt   <= '0;
    end else begin
      o_err    <= w_rej;
      o_done   <= w_next == DONE;
      o_busy   <= w_next inside {HDR, PAY, CSUM, PAD};
      o_wvalid <= w_go;
      o_pren   <= w_rd;
      r_pv     <= o_pren;
      if (w_go) o_wdata <= w_byte;
      if (w_rd) o_paddr <= r_rcnt[ADDR_W-1:0];
      if (w_acc) begin
        r_dst   <= i_dst_addr;
        r_src   <= i_src_addr;
        r_len   <= i_len;
        r_type  <= i_d_type;
        r_idx   <= '0;
        r_csum  <= '0;
        r_rcnt  <= '0;
        r_pfull <= 1'b0;
      end else begin
        if (w_sent) r_idx <= r_idx + 16'd1;
        if (w_go && r_state inside {HDR, PAY}) r_csum <= r_csum + {8'd0, w_byte};
        if (w_rd) r_rcnt <= r_rcnt + 16'd1;
        if (r_pv && !w_take) r_pbuf <= i_pdata;
        r_pfull <= r_pv ? !w_take : r_pfull && !w_take;
      end
    end
  end
endmodule

// File: tb/tb_mhp_tx.sv
// tb_mhp_tx: directed scenarios for mhp_tx with a BRAM model and a byte capture monitor.
module tb_mhp_tx;
  logic        clk = 0, rst = 1, start = 0, wready = 1;
  logic [15:0] dst = 0, src = 0, len = 0;
  logic [7:0]  typ = 0, pdata = 0, wdata;
  logic [9:0]  paddr;
  logic        pren, wvalid, busy, done, err;
  int          errors = 0, checks = 0;
  logic [7:0]  mem [0:1023];
  logic [7:0]  cap[$], expq[$];
  int          pren_cnt, addr_err, b2b_err, stall_err, done_cnt;
  logic        prev_wv;

  mhp_tx dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_dst_addr(dst), .i_src_addr(src),
    .i_d_type(typ), .i_len(len), .o_paddr(paddr), .o_pren(pren), .i_pdata(pdata),
    .o_wdata(wdata), .i_wready(wready), .o_wvalid(wvalid), .o_busy(busy),
    .o_done(done), .o_err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (pren) pdata <= mem[paddr];

  always @(posedge clk) begin
    #2;
    if (wvalid) begin
      cap.push_back(wdata);
      if (prev_wv) b2b_err++;
      if (!wready) stall_err++;
    end
    if (pren) begin
      if (int'(paddr) != pren_cnt) addr_err++;
      pren_cnt++;
    end
    if (done) done_cnt++;
    prev_wv = wvalid;
  end

  task clear_mon;
    cap.delete();
    pren_cnt = 0; addr_err = 0; b2b_err = 0; stall_err = 0; done_cnt = 0;
  endtask

  task start_frame(input logic [15:0] d, input logic [15:0] s, input logic [15:0] l, input logic [7:0] t);
    @(negedge clk);
    dst = d; src = s; len = l; typ = t; start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task wait_done(input string nm);
    int c;
    c = 0;
    while (!done && c < 3000) begin
      @(posedge clk); #3; c++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_done_timeout o_done=%0b after %0d cycles, want 1", nm, done, c);
    end
    repeat (3) @(negedge clk);
  endtask

  task wait_bytes(input string nm, input int n);
    int c;
    c = 0;
    while (cap.size() < n && c < 500) begin
      @(negedge clk); c++;
    end
    checks++;
    if (cap.size() < n) begin
      errors++;
      $display("FAIL %s_bytes_timeout got %0d bytes want %0d", nm, cap.size(), n);
    end
  endtask

  task build_exp(input logic [15:0] d, input logic [15:0] s, input logic [15:0] l, input logic [7:0] t);
    logic [15:0] sum;
    expq.delete();
    expq.push_back(d[15:8]); expq.push_back(d[7:0]);
    expq.push_back(s[15:8]); expq.push_back(s[7:0]);
    expq.push_back(l[15:8]); expq.push_back(l[7:0]);
    expq.push_back(t);
    for (int i = 0; i < int'(l); i++) expq.push_back(mem[i]);
    sum = 0;
    foreach (expq[i]) sum = sum + {8'd0, expq[i]};
    expq.push_back(sum[15:8]); expq.push_back(sum[7:0]);
    while (expq.size() < 46) expq.push_back(8'h00);
  endtask

  function automatic int first_diff();
    int n;
    n = cap.size() > expq.size() ? cap.size() : expq.size();
    for (int i = 0; i < n; i++)
      if (i >= cap.size() || i >= expq.size() || cap[i] !== expq[i]) return i;
    return -1;
  endfunction

  function automatic logic [7:0] qget(input int sel, input int i);
    if (sel == 0) return (i >= 0 && i < cap.size()) ? cap[i] : 8'hxx;
    return (i >= 0 && i < expq.size()) ? expq[i] : 8'hxx;
  endfunction

  task test_reset;
    #1;
    checks++;
    if ({wvalid, pren, busy, done, err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 00000", {wvalid, pren, busy, done, err});
    end
    checks++;
    if ({wdata, paddr} !== 18'b0) begin
      errors++;
      $display("FAIL reset_data got wdata=%h paddr=%h want 0", wdata, paddr);
    end
    repeat (3) @(negedge clk);
    rst = 0;
  endtask

  task test_n0;
    int d;
    logic [7:0] hv [9];
    hv = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'h00, 8'h00, 8'h81, 8'h02, 8'h80};
    clear_mon();
    start_frame(16'hFFFF, 16'h0001, 16'd0, 8'h81);
    checks++;
    if ({busy, wvalid} !== 2'b10) begin
      errors++;
      $display("FAIL n0_cycle1 busy,wvalid got %b want 10", {busy, wvalid});
    end
    @(posedge clk); #2;
    checks++;
    if ({wvalid, wdata} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL n0_cycle2 wvalid,wdata got %b,%h want 1,ff", wvalid, wdata);
    end
    wait_done("n0");
    expq.delete();
    foreach (hv[i]) expq.push_back(hv[i]);
    repeat (37) expq.push_back(8'h00);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL n0_stream byte %0d got %h want %h (count got %0d want %0d)", d, qget(0, d), qget(1, d), cap.size(), expq.size());
    end
    checks++;
    if (pren_cnt != 0) begin
      errors++;
      $display("FAIL n0_pren got %0d reads want 0", pren_cnt);
    end
    checks++;
    if (done_cnt != 1 || b2b_err != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL n0_handshake done_cnt=%0d b2b=%0d busy=%b want 1,0,0", done_cnt, b2b_err, busy);
    end
  endtask

  task test_n4;
    int d;
    logic [7:0] hv [13];
    hv = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h04, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h23};
    clear_mon();
    start_frame(16'h1234, 16'h5678, 16'd4, 8'h01);
    wait_bytes("n4", 3);
    @(negedge clk);
    dst = 16'hAAAA; len = 16'd5; typ = 8'h7F; start = 1;
    @(negedge clk);
    start = 0;
    wait_done("n4");
    expq.delete();
    foreach (hv[i]) expq.push_back(hv[i]);
    repeat (33) expq.push_back(8'h00);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL n4_stream byte %0d got %h want %h (count got %0d want %0d)", d, qget(0, d), qget(1, d), cap.size(), expq.size());
    end
    checks++;
    if (pren_cnt != 4 || addr_err != 0) begin
      errors++;
      $display("FAIL n4_reads got %0d reads, %0d bad addrs want 4, 0", pren_cnt, addr_err);
    end
    checks++;
    if (done_cnt != 1 || b2b_err != 0) begin
      errors++;
      $display("FAIL n4_handshake done_cnt=%0d b2b=%0d want 1,0", done_cnt, b2b_err);
    end
  endtask

  task test_boundary(input int n);
    int d;
    clear_mon();
    start_frame(16'hBEEF, 16'h0A0B, 16'(n), 8'h85);
    wait_done("boundary");
    build_exp(16'hBEEF, 16'h0A0B, 16'(n), 8'h85);
    checks++;
    if (cap.size() != (n + 9 > 46 ? n + 9 : 46)) begin
      errors++;
      $display("FAIL len%0d_count got %0d bytes want %0d", n, cap.size(), n + 9 > 46 ? n + 9 : 46);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL len%0d_stream byte %0d got %h want %h", n, d, qget(0, d), qget(1, d));
    end
    checks++;
    if (pren_cnt != n || addr_err != 0 || b2b_err != 0) begin
      errors++;
      $display("FAIL len%0d_reads reads=%0d bad=%0d b2b=%0d want %0d,0,0", n, pren_cnt, addr_err, b2b_err, n);
    end
  endtask

  task test_reject;
    int d;
    clear_mon();
    start_frame(16'h1111, 16'h2222, 16'd1016, 8'h01);
    checks++;
    if ({err, busy} !== 2'b10) begin
      errors++;
      $display("FAIL reject_pulse err,busy got %b want 10", {err, busy});
    end
    @(negedge clk);
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL reject_width err got %b want 0", err);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (cap.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reject_quiet bytes=%0d busy=%b want 0,0", cap.size(), busy);
    end
    clear_mon();
    start_frame(16'h0102, 16'h0304, 16'd1, 8'h02);
    wait_done("after_reject");
    build_exp(16'h0102, 16'h0304, 16'd1, 8'h02);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL after_reject_stream byte %0d got %h want %h", d, qget(0, d), qget(1, d));
    end
  endtask

  task test_stall;
    int d;
    clear_mon();
    start_frame(16'hC0DE, 16'h4321, 16'd8, 8'h10);
    wait_bytes("stall", 9);
    @(negedge clk);
    wready = 0;
    repeat (10) @(negedge clk);
    wready = 1;
    wait_done("stall");
    build_exp(16'hC0DE, 16'h4321, 16'd8, 8'h10);
    checks++;
    if (stall_err != 0 || b2b_err != 0) begin
      errors++;
      $display("FAIL stall_strobe wvalid-while-low=%0d b2b=%0d want 0,0", stall_err, b2b_err);
    end
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL stall_stream byte %0d got %h want %h (count got %0d want %0d)", d, qget(0, d), qget(1, d), cap.size(), expq.size());
    end
  endtask

  task test_rst_mid;
    int d;
    clear_mon();
    start_frame(16'h5555, 16'h6666, 16'd8, 8'h03);
    wait_bytes("rst_mid", 9);
    rst = 1;
    #1;
    checks++;
    if ({wvalid, pren, busy, done, err, wdata, paddr} !== 23'b0) begin
      errors++;
      $display("FAIL rst_mid_outputs got %b want all 0", {wvalid, pren, busy, done, err, wdata, paddr});
    end
    @(negedge clk);
    rst = 0;
    clear_mon();
    start_frame(16'h9876, 16'h0102, 16'd2, 8'h84);
    wait_done("rst_mid");
    build_exp(16'h9876, 16'h0102, 16'd2, 8'h84);
    d = first_diff();
    checks++;
    if (d >= 0) begin
      errors++;
      $display("FAIL rst_mid_stream byte %0d got %h want %h (count got %0d want %0d)", d, qget(0, d), qget(1, d), cap.size(), expq.size());
    end
    checks++;
    if (done_cnt != 1 || pren_cnt != 2) begin
      errors++;
      $display("FAIL rst_mid_counts done=%0d reads=%0d want 1,2", done_cnt, pren_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i + 1);
    prev_wv = 0;
    clear_mon();
    test_reset();
    test_n0();
    test_n4();
    test_boundary(37);
    test_boundary(38);
    test_reject();
    test_stall();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
